// File: rtl/rf_pkg.sv
`default_nettype none
// =============================================================================
// Module   : rf_pkg
// Brief    : Shared widths, register-0 constant and source indices used by the
//            register-file write arbiter and its per-source queues.
// Revision : 1.0
// =============================================================================
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/rf_wb_fifo.sv
`default_nettype none
// =============================================================================
// Module   : rf_wb_fifo
// Brief    : Per-source writeback queue with destination-match lookups for
//            hazard detection.
// Revision : 1.0
// =============================================================================
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic [REG_ADDR_W-1:0]   i_rd,
    input  logic [DATA_W-1:0]       i_data,
    input  logic                    i_pop,
    output logic [REG_ADDR_W-1:0]   o_rd,
    output logic [DATA_W-1:0]       o_data,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_full,
    output logic                    o_empty,
    input  logic [REG_ADDR_W-1:0]   i_query_a,
    input  logic [REG_ADDR_W-1:0]   i_query_b,
    output logic                    o_match_a,
    output logic                    o_match_b
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [PTR_W:0]        r_count;
    logic [DEPTH-1:0]      r_valid;
    logic [REG_ADDR_W-1:0] r_rd_mem   [DEPTH];
    logic [DATA_W-1:0]     r_data_mem [DEPTH];

    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic [DEPTH-1:0]      w_hit_a;
    logic [DEPTH-1:0]      w_hit_b;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_rd      = r_rd_mem[r_rptr];
    assign o_data    = r_data_mem[r_rptr];

    // Push and pop never target the same slot: that would need a queue that is
    // simultaneously full and empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr          <= r_wptr + PTR_W'(1);
                r_valid[r_wptr] <= 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr          <= r_rptr + PTR_W'(1);
                r_valid[r_rptr] <= 1'b0;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_rd_mem[r_wptr]   <= i_rd;
            r_data_mem[r_wptr] <= i_data;
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_match
            assign w_hit_a[g] = r_valid[g] && (r_rd_mem[g] == i_query_a);
            assign w_hit_b[g] = r_valid[g] && (r_rd_mem[g] == i_query_b);
        end
    endgenerate

    assign o_match_a = |w_hit_a;
    assign o_match_b = |w_hit_b;

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : rf_write_arbiter
// Brief    : Merges ALU and load writebacks onto the single register-file
//            write port with round-robin arbitration and hazard flags.
// Revision : 1.0
// =============================================================================
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = rf_pkg::DATA_W
) (
    input  logic                  Clk,
    input  logic                  Clr,
    input  logic                  aluValid,
    output logic                  aluReady,
    input  logic [REG_ADDR_W-1:0] aluRD,
    input  logic [DATA_W-1:0]     aluData,
    input  logic                  memValid,
    output logic                  memReady,
    input  logic [REG_ADDR_W-1:0] memRD,
    input  logic [DATA_W-1:0]     memData,
    output logic [REG_ADDR_W-1:0] RD,
    output logic [DATA_W-1:0]     dataRD,
    output logic                  RW,
    input  logic [REG_ADDR_W-1:0] RS,
    input  logic [REG_ADDR_W-1:0] RT,
    output logic                  hazRS,
    output logic                  hazRT,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  w_alu_push, w_mem_push;
    logic                  w_alu_pop,  w_mem_pop;
    logic                  w_alu_full, w_mem_full;
    logic                  w_alu_empty, w_mem_empty;
    logic [CNT_W-1:0]      w_alu_count, w_mem_count;
    logic [REG_ADDR_W-1:0] w_alu_rd, w_mem_rd;
    logic [DATA_W-1:0]     w_alu_data, w_mem_data;
    logic                  w_alu_hit_rs, w_alu_hit_rt;
    logic                  w_mem_hit_rs, w_mem_hit_rt;
    logic                  w_any;
    logic                  w_contend;
    logic                  w_grant;

    logic                  r_rw;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0]     r_data;
    logic                  r_rr;

    assign aluReady = !Clr && !w_alu_full;
    assign memReady = !Clr && !w_mem_full;

    // Register-0 writes complete the handshake but never occupy a slot.
    assign w_alu_push = aluValid && aluReady && (aluRD != ZERO_REG);
    assign w_mem_push = memValid && memReady && (memRD != ZERO_REG);

    rf_wb_fifo #(
        .DEPTH     (DEPTH),
        .DATA_W    (DATA_W)
    ) u_alu_q (
        .clk       (Clk),
        .rst       (Clr),
        .i_push    (w_alu_push),
        .i_rd      (aluRD),
        .i_data    (aluData),
        .i_pop     (w_alu_pop),
        .o_rd      (w_alu_rd),
        .o_data    (w_alu_data),
        .o_count   (w_alu_count),
        .o_full    (w_alu_full),
        .o_empty   (w_alu_empty),
        .i_query_a (RS),
        .i_query_b (RT),
        .o_match_a (w_alu_hit_rs),
        .o_match_b (w_alu_hit_rt)
    );

    rf_wb_fifo #(
        .DEPTH     (DEPTH),
        .DATA_W    (DATA_W)
    ) u_mem_q (
        .clk       (Clk),
        .rst       (Clr),
        .i_push    (w_mem_push),
        .i_rd      (memRD),
        .i_data    (memData),
        .i_pop     (w_mem_pop),
        .o_rd      (w_mem_rd),
        .o_data    (w_mem_data),
        .o_count   (w_mem_count),
        .o_full    (w_mem_full),
        .o_empty   (w_mem_empty),
        .i_query_a (RS),
        .i_query_b (RT),
        .o_match_a (w_mem_hit_rs),
        .o_match_b (w_mem_hit_rt)
    );

    // r_rr names the source that wins the next contended cycle.
    always_comb begin
        w_any     = !w_alu_empty || !w_mem_empty;
        w_contend = !w_alu_empty && !w_mem_empty;
        w_grant   = SRC_ALU;
        if (w_contend) begin
            w_grant = r_rr;
        end else if (w_alu_empty) begin
            w_grant = SRC_MEM;
        end
        w_alu_pop = w_any && (w_grant == SRC_ALU);
        w_mem_pop = w_any && (w_grant == SRC_MEM);
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_rw   <= 1'b0;
            r_rd   <= ZERO_REG;
            r_data <= '0;
            r_rr   <= SRC_ALU;
        end else begin
            r_rw <= w_any;
            if (w_any) begin
                r_rd   <= (w_grant == SRC_ALU) ? w_alu_rd   : w_mem_rd;
                r_data <= (w_grant == SRC_ALU) ? w_alu_data : w_mem_data;
            end
            if (w_contend) begin
                r_rr <= ~w_grant;
            end
        end
    end

    assign RW     = r_rw;
    assign RD     = r_rd;
    assign dataRD = r_data;

    assign hazRS = (RS != ZERO_REG) &&
                   (w_alu_hit_rs || w_mem_hit_rs || (r_rw && (r_rd == RS)));
    assign hazRT = (RT != ZERO_REG) &&
                   (w_alu_hit_rt || w_mem_hit_rt || (r_rw && (r_rd == RT)));

    assign busy = (w_alu_count != '0) || (w_mem_count != '0) || r_rw;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_rf_write_arbiter
// Brief    : Directed scoreboard bench for rf_write_arbiter.
// Revision : 1.0
// =============================================================================
module tb_rf_write_arbiter;

    localparam int DEPTH = 2;
    localparam int DW    = 32;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic          Clk = 1'b0;
    logic          Clr = 1'b1;
    logic          aluValid = 1'b0, memValid = 1'b0;
    logic          aluReady, memReady;
    logic [4:0]    aluRD = '0, memRD = '0;
    logic [DW-1:0] aluData = '0, memData = '0;
    logic [4:0]    RD;
    logic [DW-1:0] dataRD;
    logic          RW;
    logic [4:0]    RS = '0, RT = '0;
    logic          hazRS, hazRT, busy;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_cmp  = 0;
    int            n_fail = 0;

    logic [4:0]    a_rd[8], m_rd[8];
    logic [31:0]   a_dat[8], m_dat[8];
    int            a_n = 0, m_n = 0;

    rf_write_arbiter #(
        .DEPTH    (DEPTH),
        .DATA_W   (DW)
    ) dut (
        .Clk      (Clk),
        .Clr      (Clr),
        .aluValid (aluValid),
        .aluReady (aluReady),
        .aluRD    (aluRD),
        .aluData  (aluData),
        .memValid (memValid),
        .memReady (memReady),
        .memRD    (memRD),
        .memData  (memData),
        .RD       (RD),
        .dataRD   (dataRD),
        .RW       (RW),
        .RS       (RS),
        .RT       (RT),
        .hazRS    (hazRS),
        .hazRT    (hazRT),
        .busy     (busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk1(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every register-file write must match the head of the expected queue.
    always @(negedge Clk) begin
        if (RW === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: got rd=%0d data=%h, required no write", RD, dataRD);
            end else begin
                mon_e = exp_q.pop_front();
                if (RD !== mon_e.rd || dataRD !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL wr_data: got rd=%0d data=%h, required rd=%0d data=%h",
                             RD, dataRD, mon_e.rd, mon_e.data);
                end
            end
        end
    end

    task automatic run_src(input int src);
        int n;
        n = (src == 0) ? a_n : m_n;
        for (int i = 0; i < n; i++) begin
            int w;
            logic rdy;
            @(negedge Clk);
            if (src == 0) begin
                aluValid = 1'b1; aluRD = a_rd[i]; aluData = a_dat[i];
            end else begin
                memValid = 1'b1; memRD = m_rd[i]; memData = m_dat[i];
            end
            #1;
            w = 0;
            rdy = (src == 0) ? aluReady : memReady;
            while (!rdy && w < 40) begin
                @(negedge Clk);
                #1;
                w++;
                rdy = (src == 0) ? aluReady : memReady;
            end
            if (!rdy) begin
                n_cmp++;
                n_fail++;
                $display("FAIL src%0d_ready_timeout: got ready=0 for 40 cycles, required 1", src);
            end
        end
        @(negedge Clk);
        if (src == 0) aluValid = 1'b0;
        else          memValid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Clr = 1'b1;
        #1;
        chk1("rst_alu_ready_low", aluReady, 1'b0);
        chk1("rst_mem_ready_low", memReady, 1'b0);
        @(negedge Clk);
        Clr = 1'b0;
        RS = 5'd5;
        RT = 5'd7;
        #1;
        chk1 ("rst_rw", RW, 1'b0);
        chk32("rst_rd", 32'(RD), 32'd0);
        chk32("rst_data", dataRD, 32'd0);
        chk1 ("rst_busy", busy, 1'b0);
        chk1 ("rst_hazrs", hazRS, 1'b0);
        chk1 ("rst_hazrt", hazRT, 1'b0);
        chk1 ("rst_alu_ready", aluReady, 1'b1);
        chk1 ("rst_mem_ready", memReady, 1'b1);
    endtask

    task automatic wait_drain(input string name);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge Clk);
            #1;
            w++;
        end
        chk32(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        // Single write with latency and hazard window
        do_reset();
        RS = 5'd5;
        @(negedge Clk);
        aluValid = 1'b1; aluRD = 5'd5; aluData = 32'hDEADBEEF;
        exp_q.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
        #1;
        chk1("single_ready", aluReady, 1'b1);
        @(negedge Clk);
        aluValid = 1'b0;
        #1;
        chk1 ("single_rw_n1", RW, 1'b0);
        chk1 ("single_haz_n1", hazRS, 1'b1);
        chk1 ("single_busy_n1", busy, 1'b1);
        @(negedge Clk);
        #1;
        chk1 ("single_rw_n2", RW, 1'b1);
        chk32("single_rd_n2", 32'(RD), 32'd5);
        chk32("single_data_n2", dataRD, 32'hDEADBEEF);
        chk1 ("single_haz_n2", hazRS, 1'b1);
        @(negedge Clk);
        #1;
        chk1 ("single_rw_n3", RW, 1'b0);
        chk1 ("single_haz_n3", hazRS, 1'b0);
        chk1 ("single_busy_n3", busy, 1'b0);
        wait_drain("single_drain");

        // Register-0 drop
        do_reset();
        RS = 5'd0;
        @(negedge Clk);
        memValid = 1'b1; memRD = 5'd0; memData = 32'h1234;
        #1;
        chk1("r0_mem_ready", memReady, 1'b1);
        @(negedge Clk);
        memValid = 1'b0;
        #1;
        chk1("r0_rw_n1", RW, 1'b0);
        chk1("r0_busy_n1", busy, 1'b0);
        chk1("r0_haz_n1", hazRS, 1'b0);
        @(negedge Clk);
        #1;
        chk1("r0_rw_n2", RW, 1'b0);
        chk1("r0_busy_n2", busy, 1'b0);

        // Contention: strict alternation starting with ALU, RW held high
        do_reset();
        a_n = 4; m_n = 4;
        for (int i = 0; i < 4; i++) begin
            a_rd[i]  = 5'(1 + i);  a_dat[i] = 32'hA000_0000 + 32'(i);
            m_rd[i]  = 5'(11 + i); m_dat[i] = 32'hB000_0000 + 32'(i);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{rd: a_rd[i], data: a_dat[i]});
            exp_q.push_back('{rd: m_rd[i], data: m_dat[i]});
        end
        fork
            run_src(0);
            run_src(1);
            begin
                int w;
                w = 0;
                @(negedge Clk);
                #1;
                while (RW !== 1'b1 && w < 20) begin
                    @(negedge Clk);
                    #1;
                    w++;
                end
                for (int k = 0; k < 8; k++) begin
                    chk1("cont_rw_held", RW, 1'b1);
                    @(negedge Clk);
                    #1;
                end
            end
        join
        wait_drain("cont_drain");

        // Backpressure at DEPTH 2 with both sources at full rate
        do_reset();
        a_n = 6; m_n = 6;
        for (int i = 0; i < 6; i++) begin
            a_rd[i] = 5'(21 + i); a_dat[i] = 32'hC000_0000 + 32'(i);
            m_rd[i] = 5'(8 + i);  m_dat[i] = 32'hD000_0000 + 32'(i);
        end
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{rd: a_rd[i], data: a_dat[i]});
            exp_q.push_back('{rd: m_rd[i], data: m_dat[i]});
        end
        fork
            run_src(0);
            run_src(1);
            begin
                @(negedge Clk);
                repeat (3) @(negedge Clk);
                #1;
                chk1("bp_alu_ready_e3", aluReady, 1'b0);
                chk1("bp_mem_ready_e3", memReady, 1'b1);
                @(negedge Clk);
                #1;
                chk1("bp_alu_ready_e4", aluReady, 1'b1);
                chk1("bp_mem_ready_e4", memReady, 1'b0);
                @(negedge Clk);
                #1;
                chk1("bp_alu_ready_e5", aluReady, 1'b0);
            end
        join
        wait_drain("bp_drain");

        // Reset mid-flight: only the entry already on the write port is seen
        do_reset();
        RS = 5'd3; RT = 5'd18;
        @(negedge Clk);
        aluValid = 1'b1; aluRD = 5'd2; aluData = 32'h2222_0000;
        memValid = 1'b1; memRD = 5'd17; memData = 32'h1717_0000;
        exp_q.push_back('{rd: 5'd2, data: 32'h2222_0000});
        @(negedge Clk);
        aluRD = 5'd3;  aluData = 32'h3333_0000;
        memRD = 5'd18; memData = 32'h1818_0000;
        @(negedge Clk);
        aluValid = 1'b0; memValid = 1'b0;
        Clr = 1'b1;
        #1;
        chk1("mid_haz_before", hazRS, 1'b1);
        @(negedge Clk);
        Clr = 1'b0;
        #1;
        chk1("mid_rw", RW, 1'b0);
        chk1("mid_busy", busy, 1'b0);
        chk1("mid_hazrs", hazRS, 1'b0);
        chk1("mid_hazrt", hazRT, 1'b0);
        chk1("mid_alu_ready", aluReady, 1'b1);
        chk1("mid_mem_ready", memReady, 1'b1);
        repeat (6) @(negedge Clk);
        #1;
        chk1("mid_busy_late", busy, 1'b0);
        wait_drain("mid_drain");

        // Same-register ordering and hazard release
        do_reset();
        RT = 5'd7;
        a_n = 3;
        for (int i = 0; i < 3; i++) begin
            a_rd[i] = 5'd7; a_dat[i] = 32'(i + 1);
            exp_q.push_back('{rd: 5'd7, data: 32'(i + 1)});
        end
        run_src(0);
        #1;
        chk1("ord_hazrt_a", hazRT, 1'b1);
        @(negedge Clk);
        #1;
        chk1("ord_hazrt_b", hazRT, 1'b1);
        @(negedge Clk);
        #1;
        chk1("ord_hazrt_off", hazRT, 1'b0);
        wait_drain("ord_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required $finish earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
